ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the shared open-drain PS2_CLK/PS2_DAT lines. It is the reverse direction of the keyboard scan-code receiver and sits beside it in the input subsystem. While `busy` is high, the receiver must ignore line activity. All logic runs on the system clock; PS2_CLK is only sampled through synchronisers, never used as a clock.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 34 +++
 rtl/ps2_host_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes
// and the microsecond-to-clock-cycle conversion used to size timers.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_ACK_IDLE,
    ST_ERR
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  function automatic int us_to_cycles(input int clk_hz, input int us);
    longint prod;
    prod = longint'(clk_hz) * longint'(us);
    return int'(prod / 64'sd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the PS/2 clock and data lines plus a registered
// falling-edge detect on the clock; shared by the host transmitter and receiver.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_s_o,
  output logic dat_s_o,
  output logic clk_fall_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_prev_q;

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign clk_s_o    = clk_sync_q[1];
  assign dat_s_o    = dat_sync_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain PS2_CLK/PS2_DAT.
// Define PS2_TX_RETRY_EN to retry a failed transfer once before flagging tx_err.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INHIBIT_US  = 120,
  parameter int START_TO_MS = 15,
  parameter int BIT_TO_US   = 2000
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_CYC   = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int START_CYC = us_to_cycles(CLK_FREQ_HZ, START_TO_MS * 1000);
  localparam int BIT_CYC   = us_to_cycles(CLK_FREQ_HZ, BIT_TO_US);
  localparam int TMR_MAX   = (START_CYC > BIT_CYC)
                             ? ((START_CYC > INH_CYC) ? START_CYC : INH_CYC)
                             : ((BIT_CYC > INH_CYC) ? BIT_CYC : INH_CYC);
  localparam int TMR_W     = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] INH_LOAD   = TMR_W'(INH_CYC - 1);
  // Two cycles are spent in ERR and the pulse cycle, so the start timeout
  // pulse lands exactly START_CYC cycles after the clock line is released.
  localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(START_CYC - 2);
  localparam logic [TMR_W-1:0] BIT_LOAD   = TMR_W'(BIT_CYC - 1);

  ps2_tx_state_e    state_q;
  logic [8:0]       frame_q;
  logic [8:0]       shreg_q;
  logic [3:0]       cnt_q;
  logic [TMR_W-1:0] tmr_q;
  logic             clk_oe_q;
  logic             dat_oe_q;
  logic             tx_ready_q;
  logic             busy_q;
  logic             tx_done_q;
  logic             tx_err_q;
`ifdef PS2_TX_RETRY_EN
  logic             retry_q;
`endif

  logic clk_s;
  logic dat_s;
  logic clk_fall;
  logic tmr_zero;

  ps2_line_sync u_sync (
    .clk        (clk),
    .rst_n      (rst),
    .ps2_clk_i  (PS2_CLK),
    .ps2_dat_i  (PS2_DAT),
    .clk_s_o    (clk_s),
    .dat_s_o    (dat_s),
    .clk_fall_o (clk_fall)
  );

  assign tmr_zero = (tmr_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (tx_valid && tx_ready_q) begin
            frame_q    <= {~^tx_data, tx_data};
            cnt_q      <= '0;
            tmr_q      <= INH_LOAD;
            clk_oe_q   <= 1'b1;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= 1'b0;
`endif
            state_q    <= ST_INHIBIT;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_INHIBIT: begin
          if (tmr_zero) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b1;
            shreg_q  <= frame_q;
            tmr_q    <= START_LOAD;
            state_q  <= ST_REQ;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_REQ, ST_SHIFT: begin
          // Edges 1..9 present data LSB-first then parity; edge 10 is the stop bit.
          if (clk_fall) begin
            tmr_q <= BIT_LOAD;
            if (cnt_q == 4'd9) begin
              dat_oe_q <= 1'b0;
              state_q  <= ST_ACK;
            end else begin
              dat_oe_q <= ~shreg_q[0];
              shreg_q  <= shreg_q >> 1;
              cnt_q    <= cnt_q + 4'd1;
              state_q  <= ST_SHIFT;
            end
          end else if (tmr_zero) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            state_q  <= ST_ERR;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            tmr_q   <= BIT_LOAD;
            state_q <= dat_s ? ST_ERR : ST_ACK_IDLE;
          end else if (tmr_zero) begin
            state_q <= ST_ERR;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_ACK_IDLE: begin
          if (clk_s && dat_s) begin
            tx_done_q  <= 1'b1;
            tx_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (tmr_zero) begin
            state_q <= ST_ERR;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_ERR: begin
`ifdef PS2_TX_RETRY_EN
          if (!retry_q) begin
            retry_q  <= 1'b1;
            cnt_q    <= '0;
            tmr_q    <= INH_LOAD;
            clk_oe_q <= 1'b1;
            state_q  <= ST_INHIBIT;
          end else begin
            tx_err_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
`else
          tx_err_q   <= 1'b1;
          tx_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PS2_CLK  = clk_oe_q ? 1'b0 : 1'bz;
  assign PS2_DAT  = dat_oe_q ? 1'b0 : 1'bz;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;
  assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model answers each request while a
// scoreboard monitor checks every done/err pulse against queued expectations.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_SILENT = 2;
  localparam int M_ABORT  = 3;
  localparam int START_TO_CYC = 15000;

  typedef struct {
    logic [7:0] data;
    int         mode;
    int         attempts;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_err;
  wire        ps2_clk, ps2_dat;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  ps2_host_tx #(
    .CLK_FREQ_HZ (1_000_000),
    .INHIBIT_US  (120),
    .START_TO_MS (15),
    .BIT_TO_US   (2000)
  ) dut (
    .clk      (clk),
    .rst      (rst_n),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .tx_done  (tx_done),
    .tx_err   (tx_err)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  int          mode_q[$];
  logic [10:0] rx_q[$];
  int          inh_q[$];
  int          n_req = 0;
  int          rel_cyc = 0;
  logic        abort_flag = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  // Device model: detects a host request, then clocks at 12.5 kHz (40+40 cycles).
  initial begin
    int          m;
    int          t0;
    int          k;
    logic [10:0] fr;
    forever begin
      @(negedge clk);
      if (ps2_clk === 1'b0 && !dev_clk_low) begin
        t0 = cyc;
        for (k = 0; k < 2000 && ps2_clk === 1'b0; k++) @(negedge clk);
        if (ps2_clk === 1'b0) begin
          n_tests++; n_fail++;
          $display("FAIL inhibit_release: clock still low after %0d cycles, expected release", k);
        end
        inh_q.push_back(cyc - t0);
        rel_cyc = cyc;
        n_req++;
        if (mode_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_request: request seen, expected none");
          m = M_SILENT;
        end else begin
          m = mode_q.pop_front();
        end
        if (m != M_SILENT) begin
          repeat (20) @(negedge clk);
          fr[0] = ps2_dat;
          for (int e = 1; e <= 11; e++) begin
            if (e == 11) begin
              dev_dat_low = (m == M_ACK);
              repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat ((e == 11) ? 8 : 40) @(negedge clk);
            dev_clk_low = 1'b0;
            if (m == M_ABORT && e == 4) begin
              abort_flag = 1'b1;
              break;
            end
            if (e == 11 && m == M_NACK) break;
            repeat (20) @(negedge clk);
            if (e <= 10) fr[e] = ps2_dat;
            if (e == 10) rx_q.push_back(fr);
            if (e == 11) dev_dat_low = 1'b0;
            else repeat (20) @(negedge clk);
          end
        end
      end
    end
  end

  // Scoreboard monitor: every done/err pulse retires one expected transfer.
  initial begin
    exp_t        e;
    int          d;
    logic [10:0] f;
    forever begin
      @(negedge clk);
      if (rst_n && (tx_done || tx_err)) begin
        chk("pulse_exclusive", 32'(tx_done & tx_err), 0);
        chk("ready_in_pulse", 32'(tx_ready), 1);
        chk("busy_in_pulse", 32'(busy), 1);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b, expected no pulse", tx_done, tx_err);
        end else begin
          e = exp_q.pop_front();
          chk("result_done", 32'(tx_done), 32'(e.mode == M_ACK));
          chk("result_err", 32'(tx_err), 32'(e.mode != M_ACK));
          chk("attempts", n_req, e.attempts);
          n_req = 0;
          while (inh_q.size() != 0) begin
            d = inh_q.pop_front();
            chk("inhibit_ge_100us", 32'(d >= 100), 1);
          end
          if (e.mode != M_SILENT) begin
            chk("frame_count", rx_q.size(), e.attempts);
            while (rx_q.size() != 0) begin
              f = rx_q.pop_front();
              chk("frame_bits", 32'(f), 32'(ref_frame(e.data)));
            end
          end else begin
            d = cyc - rel_cyc;
            n_tests++;
            if (d < START_TO_CYC - 1 || d > START_TO_CYC + 1) begin
              n_fail++;
              $display("FAIL start_timeout: err after %0d cycles, expected %0d +-1", d, START_TO_CYC);
            end
            chk("timeout_clk_released", 32'(ps2_clk), 1);
            chk("timeout_dat_released", 32'(ps2_dat), 1);
          end
        end
      end
    end
  end

  task automatic queue_exp(input logic [7:0] b, input int m);
    exp_t e;
    int   att;
    att = 1;
`ifdef PS2_TX_RETRY_EN
    if (m == M_NACK || m == M_SILENT) att = 2;
`endif
    if (m != M_ABORT) begin
      e.data = b; e.mode = m; e.attempts = att;
      exp_q.push_back(e);
    end
    for (int i = 0; i < att; i++) mode_q.push_back(m);
  endtask

  task automatic send(input logic [7:0] b, input int m);
    int k;
    queue_exp(b, m);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    for (k = 0; k < 50 && !tx_ready; k++) @(negedge clk);
    chk("accept_ready", 32'(tx_ready), 1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("ready_falls_after_accept", 32'(tx_ready), 0);
  endtask

  task automatic wait_all(input int budget);
    int k;
    for (k = 0; k < budget && (exp_q.size() != 0 || !tx_ready); k++) @(negedge clk);
    chk("drain_scoreboard", exp_q.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int k;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_done", 32'(tx_done), 0);
    chk("rst_tx_err", 32'(tx_err), 0);
    chk("rst_ps2_clk_z", 32'(ps2_clk), 1);
    chk("rst_ps2_dat_z", 32'(ps2_dat), 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send(CMD_SET_LED, M_ACK);  wait_all(3000);
    send(CMD_ENABLE, M_ACK);   wait_all(3000);
    send(8'h00, M_ACK);        wait_all(3000);
    send(CMD_RESET, M_ACK);    wait_all(3000);
    send(RSP_ACK, M_ACK);      wait_all(3000);
    send(8'h5A, M_NACK);       wait_all(6000);
    send(CMD_ENABLE, M_SILENT); wait_all(40000);

    // Abort mid-frame: bit 3 of 0xA5 is 0, so PS2_DAT is held low when reset hits.
    send(8'hA5, M_ABORT);
    for (k = 0; k < 3000 && !abort_flag; k++) @(negedge clk);
    chk("abort_reached", 32'(abort_flag), 1);
    chk("abort_dat_driven", 32'(ps2_dat), 0);
    abort_flag = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_clk_z", 32'(ps2_clk), 1);
    chk("abort_dat_z", 32'(ps2_dat), 1);
    chk("abort_ready", 32'(tx_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_req = 0;
    inh_q.delete();
    rx_q.delete();
    repeat (300) @(negedge clk);

    // Back-to-back: valid held through the done cycle with the next byte.
    queue_exp(CMD_SET_LED, M_ACK);
    queue_exp(CMD_RESET, M_ACK);
    @(negedge clk);
    tx_data  = CMD_SET_LED;
    tx_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready_fall", 32'(tx_ready), 0);
    chk("b2b_busy", 32'(busy), 1);
    tx_data = CMD_RESET;
    for (k = 0; k < 3000 && !tx_done; k++) @(negedge clk);
    chk("b2b_done_seen", 32'(tx_done), 1);
    chk("b2b_ready_in_done", 32'(tx_ready), 1);
    @(negedge clk);
    chk("b2b_accepted", 32'(tx_ready), 0);
    chk("b2b_busy_next", 32'(busy), 1);
    chk("b2b_inhibit_next", 32'(ps2_clk), 0);
    tx_valid = 1'b0;
    wait_all(3000);

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      send(b, ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK);
      wait_all(6000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
